prime_buffer: RTL and testbench
===============================

# prime_buffer

Downstream stage of the prime generator. Autonomously pulses the generator's `go`, captures each new prime when the generator returns to ready, and queues primes in a small FIFO. Exposes them to the consumer on a valid/ready stream. Decouples the generator's variable-latency search from a consumer that may stall, and reports generator error or exhaustion as a sticky flag.

## Interface
Parameters:
- `WIDTH_LOG`, default 4: data width is `1 << WIDTH_LOG`; must match the generator.
- `DEPTH_LOG`, default 2: FIFO depth is `1 << DEPTH_LOG` entries.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — **synchronous, active-low reset** (`rst == 0` resets on a clock edge).
- `gen_go`  out  1  — one-cycle request to the generator; registered.
- `gen_ready`  in  1  — generator ready.
- `gen_error`  in  1  — generator error; valid when `gen_ready` is 1.
- `gen_res`  in  `WIDTH`  — generator result; valid when `gen_ready` is 1.
- `out_valid`  out  1  — FIFO non-empty.
- `out_ready`  in  1  — consumer accepts `out_data` this cycle.
- `out_data`  out  `WIDTH`  — head-of-FIFO prime.
- `out_error`  out  1  — sticky: generator error or exhaustion; no further primes.
- `count`  out  `DEPTH_LOG+1`  — number of FIFO entries.

## Operation
- **FSM states:** `START`, `ISSUE`, `WAIT_LOW`, `WAIT_HIGH`, `HALT`.
- **START:** entered on reset. Waits for `gen_ready == 1`. The generator's post-reset `res = 1` seed is never pushed. Goes to `ISSUE`.
- **ISSUE:** if `count < DEPTH`, drives `gen_go = 1` for exactly one cycle and goes to `WAIT_LOW`. Otherwise holds with `gen_go = 0`. At most one request is in flight, so the slot stays reserved (pops only free space).
- **WAIT_LOW:** waits for `gen_ready == 0`, which is the generator acknowledging `go`. Goes to `WAIT_HIGH`.
- **WAIT_HIGH:** waits for `gen_ready == 1`. Then:
  - If `gen_error` is set, go to `HALT`.
  - Else if `gen_res <= last` (wrap-around, i.e. the width is exhausted), go to `HALT`.
  - Else push `gen_res`, set `last = gen_res`, and go to `ISSUE`.
- **HALT:** sets `out_error = 1` and never issues `gen_go` again. The FIFO keeps draining normally. Only reset leaves `HALT`.
- **`last`:** a `WIDTH`-bit register, reset to 1. Comparison is unsigned.
- **FIFO:**
  - Pop when `out_valid && out_ready`.
  - Simultaneous push and pop leaves `count` unchanged; data order is preserved.
  - Pointers are `DEPTH_LOG` bits and wrap modulo `DEPTH`.
  - `out_ready` while empty has no effect.
  - Overflow is structurally impossible; an assertion must check `count <= DEPTH`.
- **`out_data`:** driven from FIFO storage at the read pointer. When `out_valid == 0` it is don't-care, but must not be X in simulation after the first push.

## Timing
- **Reset values:** `gen_go = 0`, `out_valid = 0`, `out_data = 0`, `out_error = 0`, `count = 0`, FSM = `START`, `last = 1`.
- **`gen_go` timing:** a registered pulse, high the cycle after `ISSUE` is entered with room. The generator drops `gen_ready` one edge after sampling `go`, so `WAIT_LOW` normally lasts 1 cycle.
- **Push latency:** a push happens on the edge where `WAIT_HIGH` sees `gen_ready == 1`. `out_valid` and `count` reflect it the following cycle.
- **Minimum cycles per prime** at this stage: `ISSUE` → `WAIT_LOW` → `WAIT_HIGH` → push, i.e. 3 cycles plus the generator search time.
- **Reset mid-operation:** all state is discarded and the FIFO is emptied. `START` re-synchronises by waiting for `gen_ready`, because the generator may still be mid-search.
- **Consumer stall with FIFO full:** `ISSUE` holds. A pop re-enables issue in the cycle after the pop edge.

## Structure
- Shared header `defines.vh`: FSM state `localparam` encodings (3-bit), plus any common X-fill constants.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH_LOG`; ports push/pop/data/count, same `clk`/`rst`). `prime_buffer` holds the FSM, `last`, and the error flag.
- Estimated RTL: ~150 lines FSM + ~100 lines FIFO.

## Test plan
- **Basic run:** reset, then `out_ready = 1` with the real generator (`WIDTH_LOG = 4`) → stream is 2, 3, 5, 7, 11, 13, 17, 19, …; the seed value 1 never appears.
- **Backpressure:** `out_ready = 0` with `DEPTH_LOG = 2` → exactly 4 primes are queued (2, 3, 5, 7), `count = 4`, and `gen_go` stays low. Raise `out_ready` for one cycle → 2 is popped and one new `gen_go` pulse follows.
- **Simultaneous push/pop:** with `count = 1`, align a pop with a push edge → `count` stays 1 and order is preserved.
- **Generator error:** model drives `gen_ready = 1`, `gen_error = 1` → `out_error = 1`. Queued primes still drain, and no `gen_go` pulse is issued thereafter.
- **Exhaustion:** model returns 65521, then 3 → 65521 is pushed, 3 is not, and `out_error = 1`.
- **Reset mid-search:** drive `rst = 0` for one edge while in `WAIT_HIGH` → all outputs return to reset values, and the first prime after `gen_ready` is 2.

Source files
------------

// File: rtl/prime_buffer_pkg.sv
// Shared types for the prime buffer: controller state encoding and a sizing helper.
package prime_buffer_pkg;

  typedef enum logic [2:0] {
    StStart    = 3'd0,
    StIssue    = 3'd1,
    StWaitLow  = 3'd2,
    StWaitHigh = 3'd3,
    StHalt     = 3'd4
  } state_e;

  function automatic int unsigned pow2(input int unsigned log2v);
    return 32'd1 << log2v;
  endfunction

endpackage

// File: rtl/prime_buffer_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is always visible on pop_data.
module prime_buffer_sync_fifo
  import prime_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 valid,
  output logic                 full,
  output logic [DEPTH_LOG:0]   count
);

  localparam int unsigned DEPTH = pow2(DEPTH_LOG);
  localparam logic [DEPTH_LOG:0] DepthCnt = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != DepthCnt) || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DEPTH_LOG + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head never reads back as X.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + DEPTH_LOG'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (count_q <= DepthCnt);
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = (count_q != '0);
  assign full     = (count_q == DepthCnt);
  assign count    = count_q;

endmodule

// File: rtl/prime_buffer.sv
// Drives the prime generator one request at a time and queues strictly increasing results;
// a generator error or a non-increasing result halts issuing until reset.
module prime_buffer
  import prime_buffer_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = 4,
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        gen_go,
  input  logic                        gen_ready,
  input  logic                        gen_error,
  input  logic [(1<<WIDTH_LOG)-1:0]   gen_res,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(1<<WIDTH_LOG)-1:0]   out_data,
  output logic                        out_error,
  output logic [DEPTH_LOG:0]          count
);

  localparam int unsigned WIDTH = pow2(WIDTH_LOG);

  state_e           state_q, state_d;
  logic             gen_go_q, gen_go_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             error_q, error_d;
  logic             push;
  logic             fifo_full;

  always_comb begin
    state_d  = state_q;
    gen_go_d = 1'b0;
    last_d   = last_q;
    error_d  = error_q;
    push     = 1'b0;
    unique case (state_q)
      // The generator's post-reset seed is consumed here, never pushed.
      StStart: begin
        if (gen_ready) state_d = StIssue;
      end
      StIssue: begin
        if (!fifo_full) begin
          gen_go_d = 1'b1;
          state_d  = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!gen_ready) state_d = StWaitHigh;
      end
      StWaitHigh: begin
        if (gen_ready) begin
          // A result not above the previous one means the search wrapped.
          if (gen_error || (gen_res <= last_q)) begin
            error_d = 1'b1;
            state_d = StHalt;
          end else begin
            push    = 1'b1;
            last_d  = gen_res;
            state_d = StIssue;
          end
        end
      end
      StHalt: begin
        error_d = 1'b1;
      end
      default: begin
        state_d = StStart;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StStart;
      gen_go_q <= 1'b0;
      last_q   <= WIDTH'(1);
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gen_go_q <= gen_go_d;
      last_q   <= last_d;
      error_q  <= error_d;
    end
  end

  prime_buffer_sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (gen_res),
    .pop       (out_ready),
    .pop_data  (out_data),
    .valid     (out_valid),
    .full      (fifo_full),
    .count     (count)
  );

  assign gen_go    = gen_go_q;
  assign out_error = error_q;

endmodule

// File: tb/tb_prime_buffer.sv
// Directed-plus-random bench for prime_buffer with a behavioural generator and a queue
// scoreboard of the primes that must emerge, in order.
module tb_prime_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        gen_go;
  logic        gen_ready;
  logic        gen_error;
  logic [15:0] gen_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_error;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned exp_q[$];
  int unsigned popped[$];
  int unsigned last_m;
  bit          halted_m;

  // Generator model state
  bit          g_busy;
  int          g_lat;
  int unsigned g_cur;
  int          g_rst_wait;
  bit          g_err_inject;
  int unsigned g_override[$];
  bit          g_rise;
  int          fixed_lat;
  int          go_pulses;

  always #5 clk = ~clk;

  prime_buffer #(
    .WIDTH_LOG (4),
    .DEPTH_LOG (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gen_go    (gen_go),
    .gen_ready (gen_ready),
    .gen_error (gen_error),
    .gen_res   (gen_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_error (out_error),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned next_prime(input int unsigned x);
    for (int unsigned n = x + 1; n < 65536; n++) begin
      bit p;
      p = (n >= 2);
      for (int unsigned d = 2; d * d <= n; d++) begin
        if (n % d == 0) begin
          p = 0;
          break;
        end
      end
      if (p) return n;
    end
    return 0;
  endfunction

  task automatic deliver();
    int unsigned r;
    bit e;
    e = g_err_inject;
    g_err_inject = 0;
    if (g_override.size() != 0) r = g_override.pop_front();
    else r = next_prime(g_cur);
    if (e) r = $urandom_range(0, 65535);
    gen_res   = r[15:0];
    gen_error = e;
    gen_ready = 1'b1;
    g_busy    = 0;
    g_cur     = r;
    g_rise    = 1;
    // Only errors-free, strictly increasing results are ever queued.
    if (e || r <= last_m) halted_m = 1;
    else begin
      exp_q.push_back(r);
      last_m = r;
    end
  endtask

  // One clock: sample pre-edge, score after the edge, update the generator at the negedge.
  task automatic tick();
    bit in_rst, pop_now, go_now;
    logic [15:0] data_now;
    in_rst   = !rst;
    pop_now  = out_valid && out_ready;
    go_now   = gen_go;
    data_now = out_data;
    @(posedge clk);
    #1;
    if (!in_rst) begin
      if (pop_now) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else begin
          check("pop_data", data_now, exp_q.pop_front());
          popped.push_back(data_now);
        end
      end
      if (go_now) begin
        go_pulses++;
        check("go_when_idle", (g_busy || !gen_ready || halted_m), 0);
      end
    end
    @(negedge clk);
    check("count_le_depth", (count <= 3'd4), 1);
    check("valid_vs_count", out_valid, (count != 3'd0));
    g_rise = 0;
    if (g_rst_wait > 0) begin
      g_rst_wait--;
      if (g_rst_wait == 0) begin
        gen_ready = 1'b1;
        gen_res   = 16'd1;
        gen_error = 1'b0;
        g_cur     = 1;
      end
    end else if (go_now && !in_rst) begin
      g_busy    = 1;
      gen_ready = 1'b0;
      gen_error = 1'b0;
      g_lat     = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end else if (g_busy) begin
      g_lat--;
      if (g_lat == 0) deliver();
    end
  endtask

  task automatic do_reset(input int hold);
    rst          = 1'b0;
    out_ready    = 1'b0;
    g_busy       = 0;
    gen_ready    = 1'b0;
    gen_error    = 1'b0;
    g_rst_wait   = hold;
    g_err_inject = 0;
    g_override.delete();
    tick();
    check("rst_gen_go", gen_go, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_error", out_error, 0);
    check("rst_count", count, 0);
    rst      = 1'b1;
    exp_q.delete();
    popped.delete();
    last_m   = 1;
    halted_m = 0;
  endtask

  initial begin
    int unsigned basic_tbl[8];
    basic_tbl = '{2, 3, 5, 7, 11, 13, 17, 19};
    rst = 1'b0; out_ready = 1'b0; gen_ready = 1'b0; gen_error = 1'b0; gen_res = '0;
    fixed_lat = 0; go_pulses = 0; g_cur = 1; g_lat = 0;

    // Basic stream with a consumer that always accepts
    do_reset(3);
    out_ready = 1'b1;
    for (int i = 0; i < 400 && popped.size() < 8; i++) tick();
    check("basic_timeout", (popped.size() >= 8), 1);
    for (int i = 0; i < 8 && i < popped.size(); i++) check("basic_seq", popped[i], basic_tbl[i]);

    // Random consumer stalls
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    check("rand_count_model", (count <= 3'd4), 1);

    // Backpressure: fill the FIFO and hold
    do_reset(2);
    for (int i = 0; i < 300 && count != 3'd4; i++) tick();
    check("bp_fill_timeout", count, 4);
    go_pulses = 0;
    for (int i = 0; i < 20; i++) tick();
    check("bp_no_go", go_pulses, 0);
    check("bp_count", count, 4);
    check("bp_model_depth", exp_q.size(), 4);
    check("bp_head", out_data, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_count_after_pop", count, 3);
    check("bp_popped", (popped.size() == 1) ? popped[0] : 0, 2);
    go_pulses = 0;
    tick();
    check("bp_go_after_pop", gen_go, 1);
    for (int i = 0; i < 30; i++) tick();
    check("bp_one_go", go_pulses, 1);
    check("bp_refill", count, 4);

    // Push and pop on the same edge
    do_reset(2);
    fixed_lat = 3;
    for (int i = 0; i < 100 && count != 3'd1; i++) tick();
    check("sim_fill_timeout", count, 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (g_rise) break;
    end
    check("sim_rise_seen", g_rise, 1);
    check("sim_pre_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sim_count", count, 1);
    check("sim_popped", (popped.size() == 1) ? popped[0] : 0, 2);
    check("sim_head", out_data, 3);
    fixed_lat = 0;

    // Generator error: halt, then drain
    do_reset(2);
    for (int i = 0; i < 200 && count != 3'd2; i++) tick();
    check("err_fill_timeout", count, 2);
    g_err_inject = 1;
    for (int i = 0; i < 100 && out_error !== 1'b1; i++) tick();
    check("err_flag", out_error, 1);
    check("err_count", count, exp_q.size());
    go_pulses = 0;
    for (int i = 0; i < 30; i++) tick();
    check("err_no_go", go_pulses, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && out_valid; i++) tick();
    check("err_drained_model", exp_q.size(), 0);
    check("err_drained_count", count, 0);
    check("err_sticky", out_error, 1);
    check("err_no_go_drain", go_pulses, 0);

    // Exhaustion: a non-increasing result halts
    do_reset(2);
    out_ready = 1'b1;
    g_override.push_back(65521);
    g_override.push_back(3);
    for (int i = 0; i < 100 && out_error !== 1'b1; i++) tick();
    check("exh_flag", out_error, 1);
    for (int i = 0; i < 50 && out_valid; i++) tick();
    check("exh_pop_count", popped.size(), 1);
    check("exh_value", (popped.size() >= 1) ? popped[0] : 0, 65521);
    check("exh_count", count, 0);

    // Reset while the generator is mid-search
    do_reset(2);
    out_ready = 1'b1;
    fixed_lat = 6;
    for (int i = 0; i < 300 && popped.size() < 2; i++) tick();
    check("mid_pre_timeout", (popped.size() >= 2), 1);
    for (int i = 0; i < 100 && !(g_busy && !gen_ready && g_lat <= 4); i++) tick();
    check("mid_in_search", (g_busy && !gen_ready && g_lat <= 4), 1);
    fixed_lat = 0;
    do_reset(4);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && popped.size() < 1; i++) tick();
    check("mid_first", (popped.size() >= 1) ? popped[0] : 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
